// File: rtl/kypd_scan_evt.sv
// ---------------------------------------------------------------------------
// kypd_scan_evt
//   Row/column scanner for a ROWS x COLS passive button matrix.
//   - Drives one row low at a time; every other row is released (Z).
//   - Samples the columns once per row, part-way through the row period,
//     after the lines have settled.
//   - Debounces each key per frame, then publishes a stable level vector.
//   - Turns stable-level changes into a queued stream of press/release events.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   kypd_row     row drives: active row 0, others Z
//   kypd_col     column sense inputs (pulled up, 0 = pressed)
//   btn_state    debounced key levels, bit = row*COLS+col
//   frame_ready  1-cycle pulse on the first cycle a new btn_state is visible
//   evt_valid    event FIFO non-empty
//   evt_ready    consumer takes the head event when evt_valid && evt_ready
//   evt_key      key index of the head event
//   evt_press    1 = press, 0 = release
//   evt_ovf      sticky flag: an event was lost because the FIFO was full
//   evt_drop_cnt saturating count of lost events (KYPD_EVT_DROP_CNT_EN only)
//
// Build option
//   KYPD_EVT_DROP_CNT_EN  when defined, adds the evt_drop_cnt output.
// ---------------------------------------------------------------------------
module kypd_scan_evt #(
  parameter int ROWS           = 5,
  parameter int COLS           = 5,
  parameter int CLOCKS_PER_ROW = 200000,
  parameter int SAMPLE_CLK     = CLOCKS_PER_ROW / 2 - 1,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 8,
  localparam int NK            = ROWS * COLS,
  localparam int KW            = $clog2(NK)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] kypd_row,
  input  logic [COLS-1:0] kypd_col,
  output logic [NK-1:0]   btn_state,
  output logic            frame_ready,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_key,
  output logic            evt_press,
  output logic            evt_ovf
`ifdef KYPD_EVT_DROP_CNT_EN
  ,
  output logic [7:0]      evt_drop_cnt
`endif
);

  localparam int CW = (CLOCKS_PER_ROW > 1) ? $clog2(CLOCKS_PER_ROW) : 1;
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLOCKS_PER_ROW - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_CLK);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_SCANS - 1);
  localparam logic [AW:0]   OCC_FULL   = (AW + 1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  logic [CW-1:0] count_reg;
  logic [RW-1:0] rowcount_reg;
  logic          sample;
  logic          frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      rowcount_reg <= '0;
    end else if (count_reg == CNT_LAST) begin
      count_reg    <= '0;
      rowcount_reg <= (rowcount_reg == ROW_LAST) ? '0 : rowcount_reg + 1'b1;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign sample    = (count_reg == CNT_SAMPLE);
  assign frame_end = (count_reg == CNT_LAST) && (rowcount_reg == ROW_LAST);

  // -------------------------------------------------------------------------
  // Row drive and raw frame capture. Rows come straight from the registered
  // row counter, so exactly one row is low even while rst is held.
  // -------------------------------------------------------------------------
  logic [NK-1:0] raw_flat;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [COLS-1:0] row_raw_reg;

    assign kypd_row[gi] = (rowcount_reg == RW'(gi)) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
      if (rst) begin
        row_raw_reg <= '0;
      end else if (sample && (rowcount_reg == RW'(gi))) begin
        row_raw_reg <= ~kypd_col;
      end
    end

    assign raw_flat[gi*COLS +: COLS] = row_raw_reg;
  end

  // -------------------------------------------------------------------------
  // Per-key debounce. The changed bit is set at frame end when the stable
  // level flips, and cleared again once the serialiser has emitted it.
  // -------------------------------------------------------------------------
  logic [NK-1:0] stable_flat;
  logic [NK-1:0] chg_flat;
  logic [NK-1:0] pend_onehot;

  for (genvar gi = 0; gi < NK; gi++) begin : g_key
    logic [DW-1:0] deb_cnt_reg;
    logic          stable_reg;
    logic          chg_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        deb_cnt_reg <= '0;
        stable_reg  <= 1'b0;
        chg_reg     <= 1'b0;
      end else if (frame_end) begin
        if (raw_flat[gi] == stable_reg) begin
          deb_cnt_reg <= '0;
          chg_reg     <= 1'b0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          stable_reg  <= ~stable_reg;
          deb_cnt_reg <= '0;
          chg_reg     <= 1'b1;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
          chg_reg     <= 1'b0;
        end
      end else if (pend_onehot[gi]) begin
        chg_reg <= 1'b0;
      end
    end

    assign stable_flat[gi] = stable_reg;
    assign chg_flat[gi]    = chg_reg;
  end

  logic frame_ready_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ready_reg <= 1'b0;
    end else begin
      frame_ready_reg <= frame_end;
    end
  end

  assign btn_state   = stable_flat;
  assign frame_ready = frame_ready_reg;

  // -------------------------------------------------------------------------
  // Event serialiser: isolate the lowest pending key (x & -x) and encode it.
  // -------------------------------------------------------------------------
  logic          pend;
  logic [KW-1:0] pend_key;
  logic          pend_press;

  assign pend_onehot = chg_flat & (~chg_flat + NK'(1));
  assign pend        = |chg_flat;
  assign pend_press  = |(stable_flat & pend_onehot);

  always_comb begin
    pend_key = '0;
    for (int k = 0; k < NK; k++) begin
      if (pend_onehot[k]) begin
        pend_key = pend_key | KW'(k);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO, first-word-fall-through. A push into a full FIFO still
  // succeeds when a pop happens in the same cycle.
  // -------------------------------------------------------------------------
  logic [KW:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   occ_reg;
  logic          ovf_reg;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (occ_reg == OCC_FULL);
  assign pop  = evt_valid && evt_ready;
  assign push = pend && (!full || pop);
  assign drop = pend && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {pend_key, pend_press};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      occ_reg <= occ_reg + (AW + 1)'(push) - (AW + 1)'(pop);
      if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign evt_valid              = (occ_reg != '0);
  assign {evt_key, evt_press}   = fifo_mem[rd_ptr_reg];
  assign evt_ovf                = ovf_reg;

`ifdef KYPD_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign evt_drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_kypd_scan_evt.sv
// ---------------------------------------------------------------------------
// tb_kypd_scan_evt
//   Bench for kypd_scan_evt with a small scan period. A frame-level reference
//   model produces the expected debounced levels and event stream; a monitor
//   compares the DUT against it every cycle and on each event handshake.
// ---------------------------------------------------------------------------
module tb_kypd_scan_evt;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int NK    = ROWS * COLS;
  localparam int CPR   = 32;
  localparam int FRAME = CPR * ROWS;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0] key;
    logic       press;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [4:0]  kypd_row;
  logic [4:0]  kypd_col;
  logic [24:0] btn_state;
  logic        frame_ready;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_key;
  logic        evt_press;
  logic        evt_ovf;
`ifdef KYPD_EVT_DROP_CNT_EN
  logic [7:0]  evt_drop_cnt;
`endif

  kypd_scan_evt #(
    .ROWS(ROWS), .COLS(COLS), .CLOCKS_PER_ROW(CPR), .SAMPLE_CLK(15),
    .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .kypd_row(kypd_row), .kypd_col(kypd_col),
    .btn_state(btn_state), .frame_ready(frame_ready),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .evt_ovf(evt_ovf)
`ifdef KYPD_EVT_DROP_CNT_EN
    , .evt_drop_cnt(evt_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Time base: clocks since reset, giving the active row and frame phase.
  int tb_n = 0;
  always @(posedge clk) begin
    if (rst) tb_n <= 0;
    else     tb_n <= tb_n + 1;
  end

  // Keypad matrix: pressed keys in the currently scanned row pull columns low.
  logic [24:0] keys = '0;
  int          cur_row;
  always_comb begin
    cur_row  = (tb_n / CPR) % ROWS;
    kypd_col = ~keys[cur_row*COLS +: COLS];
  end

  // Ready driver: 0, 1, or random per cycle.
  int rdy_mode = 1;
  initial begin
    evt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      evt_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Reference model (frame-level debounce, queue-level FIFO).
  // -------------------------------------------------------------------------
  logic [24:0] m_stable = '0;
  int          m_cnt [NK];
  ev_t         ser_q [$];
  ev_t         exp_q [$];
  int          m_occ   = 0;
  bit          m_ovf   = 1'b0;
  int          m_drops = 0;

  always @(posedge clk) begin : p_model
    bit  pop_now;
    ev_t e;
    if (rst) begin
      m_stable = '0;
      for (int k = 0; k < NK; k++) m_cnt[k] = 0;
      ser_q.delete();
      exp_q.delete();
      m_occ   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      pop_now = (m_occ > 0) && evt_ready;
      if (ser_q.size() > 0) begin
        e = ser_q.pop_front();
        if (m_occ < DEPTH || pop_now) begin
          exp_q.push_back(e);
          m_occ++;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (pop_now) m_occ--;
      if (tb_n % FRAME == FRAME - 1) begin
        for (int k = 0; k < NK; k++) begin
          if (keys[k] == m_stable[k]) begin
            m_cnt[k] = 0;
          end else begin
            m_cnt[k]++;
            if (m_cnt[k] == DEB) begin
              m_stable[k] = ~m_stable[k];
              m_cnt[k]    = 0;
              ser_q.push_back('{key: 5'(k), press: m_stable[k]});
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin : p_monitor
    ev_t e;
    forever begin
      @(negedge clk);
      chk("evt_valid", int'(evt_valid), int'(m_occ > 0));
      chk("evt_ovf", int'(evt_ovf), int'(m_ovf));
      chk("btn_state", int'(btn_state), int'(m_stable));
      if (frame_ready || (tb_n % FRAME == 0 && tb_n != 0))
        chk("frame_ready", int'(frame_ready), int'(tb_n % FRAME == 0 && tb_n != 0));
`ifdef KYPD_EVT_DROP_CNT_EN
      chk("evt_drop_cnt", int'(evt_drop_cnt), m_drops);
`endif
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          chk("evt_unexpected_key", int'(evt_key), -1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_key", int'(evt_key), int'(e.key));
          chk("evt_press", int'(evt_press), int'(e.press));
          $display("event key=%0d press=%0d @%0t", evt_key, evt_press, $time);
        end
      end
    end
  end

  // Advance to just after the next frame boundary (bounded wait).
  task automatic next_frame();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(posedge clk);
      #2;
      if (tb_n % FRAME == 0) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("frame_wait_timeout", 0, 1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_btn_state", int'(btn_state), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_ovf", int'(evt_ovf), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Idle scanning.
    frames(2);

    // Single held key r2c3 = 13, then release.
    keys[13] = 1'b1;
    frames(4);
    keys[13] = 1'b0;
    frames(4);

    // Key 7 bouncing every frame: never settles.
    for (int i = 0; i < 6; i++) begin
      keys[7] = ~keys[7];
      next_frame();
    end
    keys = '0;
    frames(3);

    // Three keys in the same frame: ordered events.
    keys = 25'h0; keys[0] = 1'b1; keys[4] = 1'b1; keys[24] = 1'b1;
    frames(4);
    keys = '0;
    frames(4);

    // Six presses with the consumer stalled: overflow.
    rdy_mode = 0;
    keys = 25'h0; keys[1] = 1'b1; keys[2] = 1'b1; keys[3] = 1'b1;
    keys[5] = 1'b1; keys[8] = 1'b1; keys[9] = 1'b1;
    frames(4);
    chk("ovf_after_stall", int'(evt_ovf), 1);
    rdy_mode = 1;
    keys = '0;
    frames(4);

    // Full FIFO with simultaneous pop and push.
    rdy_mode = 0;
    keys = 25'h0; keys[10] = 1'b1; keys[11] = 1'b1; keys[12] = 1'b1;
    keys[14] = 1'b1; keys[15] = 1'b1; keys[16] = 1'b1;
    frames(3);
    repeat (3) @(posedge clk);
    #2;
    rdy_mode = 1;
    frames(1);
    keys = '0;
    frames(4);

    // Reset in the middle of serialisation.
    keys = 25'h0; keys[3] = 1'b1; keys[17] = 1'b1; keys[20] = 1'b1; keys[22] = 1'b1;
    frames(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_evt_valid", int'(evt_valid), 0);
    chk("midrst_btn_state", int'(btn_state), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    frames(4);
    keys = '0;
    frames(4);

    // Random keys and random consumer.
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      keys = keys ^ (25'($urandom) & 25'($urandom) & 25'($urandom));
      next_frame();
    end
    keys = '0;
    rdy_mode = 1;
    frames(5);

    chk("drain_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
